// File: rtl/mc_timing_gen_if.sv
// Control/status bundle between the 8051 timing generator and its consumers.
// The master drives advance/stall/length requests; the slave reports the slot timing and strobes.
interface mc_timing_gen_if;
    logic       en;
    logic       stall_req;
    logic [1:0] instr_len;
    logic [3:0] slot;
    logic [2:0] state;
    logic       phase;
    logic       adv_stb;
    logic       mc_end;
    logic       instr_end;
    logic       ale;
    logic       stalled;

    modport master (
        output en, stall_req, instr_len,
        input  slot, state, phase, adv_stb, mc_end, instr_end, ale, stalled
    );

    modport slave (
        input  en, stall_req, instr_len,
        output slot, state, phase, adv_stb, mc_end, instr_end, ale, stalled
    );
endinterface

// File: rtl/mc_timing_gen.sv
// Machine-cycle timing generator for the 8051 core: sequences S1P1..S6P2 on divided ticks,
// emits ALE and cycle/instruction strobes, and can hold at the last slot on a stall request.
module mc_timing_gen #(
    parameter int unsigned SLOTS  = 12,
    parameter bit          ALE_EN = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst,
    mc_timing_gen_if.slave  bus
);
    localparam int unsigned SW       = 4;
    localparam int unsigned HALF     = SLOTS / 2;
    localparam logic [SW-1:0] LAST   = SW'(SLOTS - 1);
    localparam logic [SW-1:0] ALE_S0 = SW'(1);
    localparam logic [SW-1:0] ALE_S1 = SW'(2);
    localparam logic [SW-1:0] ALE_S2 = SW'(HALF + 1);
    localparam logic [SW-1:0] ALE_S3 = SW'(HALF + 2);

    logic [SW-1:0] r_slot;
    logic          r_adv_stb;
    logic          r_mc_end;
    logic          r_instr_end;
    logic          r_ale;
    logic          r_stalled;
    logic [1:0]    r_mc_idx;
    logic [2:0]    r_len;

    logic [SW-1:0] w_slot_n;
    logic          w_adv_n;
    logic          w_mc_end_n;
    logic          w_instr_end_n;
    logic          w_ale_n;
    logic          w_stalled_n;
    logic [1:0]    w_mc_idx_n;
    logic [2:0]    w_len_n;
    logic [2:0]    w_len_dec;

    // Machine cycles per instruction: 0/1 -> 1, 2 -> 2, 3 -> 4.
    always_comb begin
        w_len_dec = 3'd1;
        case (bus.instr_len)
            2'd2:    w_len_dec = 3'd2;
            2'd3:    w_len_dec = 3'd4;
            default: w_len_dec = 3'd1;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_slot      <= '0;
            r_adv_stb   <= 1'b0;
            r_mc_end    <= 1'b0;
            r_instr_end <= 1'b0;
            r_ale       <= 1'b0;
            r_stalled   <= 1'b0;
            r_mc_idx    <= 2'd0;
            r_len       <= 3'd1;
        end else begin
            r_slot      <= w_slot_n;
            r_adv_stb   <= w_adv_n;
            r_mc_end    <= w_mc_end_n;
            r_instr_end <= w_instr_end_n;
            r_ale       <= w_ale_n;
            r_stalled   <= w_stalled_n;
            r_mc_idx    <= w_mc_idx_n;
            r_len       <= w_len_n;
        end
    end

    // Next-state: advance on en, hold at the last slot while stalled, count machine cycles on wrap.
    always_comb begin
        w_slot_n      = r_slot;
        w_adv_n       = 1'b0;
        w_mc_end_n    = 1'b0;
        w_instr_end_n = 1'b0;
        w_stalled_n   = r_stalled;
        w_mc_idx_n    = r_mc_idx;
        w_len_n       = r_len;
        if (bus.en) begin
            if (r_slot != LAST) begin
                w_slot_n    = r_slot + SW'(1);
                w_adv_n     = 1'b1;
                w_stalled_n = 1'b0;
            end else if (bus.stall_req) begin
                w_stalled_n = 1'b1;
            end else begin
                w_slot_n    = '0;
                w_stalled_n = 1'b0;
                w_adv_n     = 1'b1;
                w_mc_end_n  = 1'b1;
                if ({1'b0, r_mc_idx} == (r_len - 3'd1)) begin
                    w_instr_end_n = 1'b1;
                    w_mc_idx_n    = 2'd0;
                    w_len_n       = w_len_dec;
                end else begin
                    w_mc_idx_n    = r_mc_idx + 2'd1;
                end
            end
        end
        // ALE is registered from the next slot so it lines up with the slot it belongs to.
        w_ale_n = ALE_EN && !w_stalled_n &&
                  ((w_slot_n == ALE_S0) || (w_slot_n == ALE_S1) ||
                   (w_slot_n == ALE_S2) || (w_slot_n == ALE_S3));
    end

    // Outputs: state/phase decode straight from the registered slot.
    always_comb begin
        bus.slot      = r_slot;
        bus.state     = r_slot[3:1] + 3'd1;
        bus.phase     = r_slot[0];
        bus.adv_stb   = r_adv_stb;
        bus.mc_end    = r_mc_end;
        bus.instr_end = r_instr_end;
        bus.ale       = r_ale;
        bus.stalled   = r_stalled;
    end
endmodule

// File: tb/tb_mc_timing_gen.sv
// Scoreboard bench for mc_timing_gen (SLOTS=12, ALE_EN=1): a reference model queues the expected
// output vector as each tick is driven; each test task pops and compares after the clock edge.
module tb_mc_timing_gen;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    mc_timing_gen_if bus ();

    mc_timing_gen #(.SLOTS(12), .ALE_EN(1'b1)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] sb[$];

    // Reference model state.
    int m_slot = 0;
    int m_idx  = 0;
    int m_len  = 1;
    bit m_stalled = 1'b0;

    // {slot, state, phase, adv_stb, mc_end, instr_end, ale, stalled}
    function automatic logic [12:0] model_step(bit r, bit e, bit st, logic [1:0] il);
        bit adv = 0, mce = 0, ie = 0, a;
        if (r) begin
            m_slot = 0; m_idx = 0; m_len = 1; m_stalled = 0;
        end else if (e) begin
            if (m_slot < 11) begin
                m_slot++; adv = 1;
            end else if (st) begin
                m_stalled = 1;
            end else begin
                m_slot = 0; m_stalled = 0; adv = 1; mce = 1;
                if (m_idx == m_len - 1) begin
                    ie = 1; m_idx = 0;
                    m_len = (il == 2'd3) ? 4 : (il == 2'd2) ? 2 : 1;
                end else begin
                    m_idx++;
                end
            end
        end
        a = !m_stalled && (m_slot == 1 || m_slot == 2 || m_slot == 7 || m_slot == 8);
        return {4'(m_slot), 3'(m_slot / 2 + 1), 1'(m_slot % 2), adv, mce, ie, a, m_stalled};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.slot, bus.state, bus.phase, bus.adv_stb, bus.mc_end,
                bus.instr_end, bus.ale, bus.stalled};
    endfunction

    task automatic drive(bit r, bit e, bit st, logic [1:0] il);
        @(negedge clk_in);
        rst = r; bus.en = e; bus.stall_req = st; bus.instr_len = il;
        sb.push_back(model_step(r, e, st, il));
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp, got;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 2'd0);
            exp = sb.pop_front(); got = obs();
            n_checks++;
            if (got !== exp) $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_free_run();
        logic [12:0] exp, got;
        int mce_cnt = 0, ale_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            drive(0, 1, 0, 2'd0);
            exp = sb.pop_front(); got = obs();
            mce_cnt += int'(bus.mc_end);
            ale_cnt += int'(bus.ale);
            n_checks++;
            if (got !== exp) $display("FAIL free_run[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (mce_cnt !== 2) $display("FAIL free_run_mc_end_count got=%0d exp=2", mce_cnt);
        else n_pass++;
        n_checks++;
        if (ale_cnt !== 8) $display("FAIL free_run_ale_count got=%0d exp=8", ale_cnt);
        else n_pass++;
    endtask

    task automatic test_en_gap();
        logic [12:0] exp, got;
        int adv_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, (i % 3) == 0, 0, 2'd0);
            exp = sb.pop_front(); got = obs();
            adv_cnt += int'(bus.adv_stb);
            n_checks++;
            if (got !== exp) $display("FAIL en_gap[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (adv_cnt !== 6) $display("FAIL en_gap_adv_count got=%0d exp=6", adv_cnt);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [12:0] exp, got;
        int guard = 0;
        while (m_slot != 11 && guard < 20) begin
            drive(0, 1, 1, 2'd0);   // stall_req ignored away from the last slot
            exp = sb.pop_front(); got = obs(); guard++;
            n_checks++;
            if (got !== exp) $display("FAIL stall_seek got=%h exp=%h", got, exp);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, i != 2, 1, 2'd0);
            exp = sb.pop_front(); got = obs();
            n_checks++;
            if (got !== exp || bus.slot !== 4'd11 || bus.stalled !== 1'b1 || bus.ale !== 1'b0
                || bus.mc_end !== 1'b0)
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        drive(0, 1, 0, 2'd0);
        exp = sb.pop_front(); got = obs();
        n_checks++;
        if (got !== exp || bus.slot !== 4'd0 || bus.mc_end !== 1'b1 || bus.stalled !== 1'b0)
            $display("FAIL stall_release got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_instr_len();
        logic [12:0] exp, got;
        logic [1:0] lens[3] = '{2'd2, 2'd3, 2'd0};
        int mcs[3]  = '{4, 8, 4};
        int ends[3] = '{2, 2, 4};
        for (int p = 0; p < 3; p++) begin
            int ie_cnt = 0, ie_mod = 0;
            for (int i = 0; i < mcs[p] * 12; i++) begin
                drive(0, 1, 0, lens[p]);
                exp = sb.pop_front(); got = obs();
                ie_cnt += int'(bus.instr_end);
                ie_mod += int'(exp[2]);
                n_checks++;
                if (got !== exp) $display("FAIL instr_len%0d[%0d] got=%h exp=%h", lens[p], i, got, exp);
                else n_pass++;
            end
            n_checks++;
            if (ie_cnt !== ends[p] || ie_mod !== ends[p])
                $display("FAIL instr_len%0d_end_count got=%0d exp=%0d", lens[p], ie_cnt, ends[p]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] exp, got;
        int ie_cnt = 0, guard = 0;
        while (m_slot != 5 && guard < 20) begin
            drive(0, 1, 0, 2'd3);
            void'(sb.pop_front()); guard++;
        end
        drive(1, 1, 0, 2'd3);
        exp = sb.pop_front(); got = obs();
        n_checks++;
        if (got !== exp || got !== 13'b0000_001_0_0_0_0_0_0)
            $display("FAIL mid_reset got=%h exp=%h", got, exp);
        else n_pass++;
        // len must be back to 1: first wrap ends the instruction despite instr_len=3
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, 2'd3);
            exp = sb.pop_front(); got = obs();
            ie_cnt += int'(bus.instr_end);
            n_checks++;
            if (got !== exp) $display("FAIL post_reset[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (ie_cnt !== 1) $display("FAIL post_reset_instr_end got=%0d exp=1", ie_cnt);
        else n_pass++;
    endtask

    initial begin
        bus.en = 1'b0; bus.stall_req = 1'b0; bus.instr_len = 2'd0;
        test_reset();
        test_free_run();
        test_en_gap();
        test_stall();
        test_instr_len();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
